// File: rtl/camera_capture_ctrl.sv
// Camera capture controller: sequences sensor power-up and configuration, then
// stores frame-aligned RGB565 pixels as 12-bit RGB444 words into a frame buffer.
module camera_capture_ctrl #(
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int ADDR_W       = 17,
  parameter int PWRUP_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_req,
  input  logic              continuous,
  input  logic              cfg_done,
  input  logic              pixel_valid,
  input  logic [15:0]       pixel_data,
  input  logic              frame_done,
  output logic              cfg_start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              frame_ready,
  output logic              overrun,
  output logic              short_frame,
  output logic [2:0]        o_dbg_state
);

  // Handshake: pixel_valid and frame_done are single-cycle strobes with no
  // back-pressure; each accepted pixel appears as a one-cycle wr_en pulse on
  // the following cycle, and the frame buffer must accept every write.

  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W     = ADDR_W + 1;
  localparam int PW_W      = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_TOTAL);
  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PWRUP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PWRUP   = 3'd0,
    ST_CONFIG  = 3'd1,
    ST_READY   = 3'd2,
    ST_ARM     = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW_W-1:0]   r_pwr_cnt;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [CNT_W-1:0]  w_pix_eff;

  logic w_pwr_done;
  logic w_req_accept;
  logic w_arm_start;
  logic w_pix_accept;
  logic w_pix_over;
  logic w_frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_PWRUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pwr_done   = 1'b0;
    w_req_accept = 1'b0;
    w_arm_start  = 1'b0;
    w_pix_accept = 1'b0;
    w_pix_over   = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_PWRUP: begin
        if (r_pwr_cnt == PW_LAST) begin
          w_state_nxt = ST_CONFIG;
          w_pwr_done  = 1'b1;
        end
      end
      ST_CONFIG: begin
        if (cfg_done) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (capture_req) begin
          w_state_nxt  = ST_ARM;
          w_req_accept = 1'b1;
        end
      end
      ST_ARM: begin
        // Pixels seen here belong to a partial frame and are dropped.
        if (frame_done) begin
          w_state_nxt = ST_CAPTURE;
          w_arm_start = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (pixel_valid) begin
          if (r_pix_cnt < PIX_LAST) begin
            w_pix_accept = 1'b1;
          end else begin
            w_pix_over = 1'b1;
          end
        end
        if (frame_done) begin
          w_frame_end = 1'b1;
          w_state_nxt = continuous ? ST_CAPTURE : ST_READY;
        end
      end
      default: begin
        w_state_nxt = ST_PWRUP;
      end
    endcase
  end

  // A pixel coincident with frame_done still counts toward frame completeness.
  assign w_pix_eff = r_pix_cnt + CNT_W'(w_pix_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwr_cnt <= '0;
    end else if (r_state == ST_PWRUP && !w_pwr_done) begin
      r_pwr_cnt <= r_pwr_cnt + 1'b1;
    end else begin
      r_pwr_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= '0;
    end else if (w_arm_start || w_frame_end) begin
      r_pix_cnt <= '0;
    end else if (w_pix_accept) begin
      r_pix_cnt <= r_pix_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= w_pix_accept;
      if (w_pix_accept) begin
        wr_addr <= r_pix_cnt[ADDR_W-1:0];
        wr_data <= {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_start   <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      cfg_start   <= w_pwr_done;
      frame_ready <= w_frame_end;
      if (w_req_accept) begin
        overrun <= 1'b0;
      end else if (w_pix_over) begin
        overrun <= 1'b1;
      end
      if (w_req_accept) begin
        short_frame <= 1'b0;
      end else if (w_frame_end && (w_pix_eff < PIX_LAST)) begin
        short_frame <= 1'b1;
      end
    end
  end

  assign busy        = (r_state != ST_READY);
  assign o_dbg_state = r_state;

endmodule

// File: doc/camera_capture_ctrl.md
CAMERA_CAPTURE_CTRL -- requirements
Module: camera_capture_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320: pixels per line stored.
REQ-002 SHALL have parameter V_ACTIVE, default 240: lines per frame stored.
REQ-003 SHALL have parameter ADDR_W, default 17: frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
REQ-004 SHALL have parameter PWRUP_CYCLES, default 1000000: sensor power-up wait in clk cycles; minimum 1.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port capture_req, input, 1: one-cycle pulse requesting capture.
REQ-008 SHALL have port continuous, input, 1: 1 = re-arm after every frame; sampled at each frame end.
REQ-009 SHALL have port cfg_done, input, 1: level from sensor configurator, 1 when register load is complete.
REQ-010 SHALL have port pixel_valid, input, 1: one-cycle strobe, RGB565 pixel present (already in clk domain).
REQ-011 SHALL have port pixel_data, input, 16: RGB565 pixel.
REQ-012 SHALL have port frame_done, input, 1: one-cycle strobe at sensor frame boundary (vsync).
REQ-013 SHALL have port cfg_start, output, 1: one-cycle pulse starting sensor configuration.
REQ-014 SHALL have ports wr_en (1), wr_addr (ADDR_W) and wr_data (12), outputs: frame-buffer write port.
REQ-015 SHALL have ports busy, frame_ready, overrun and short_frame, outputs, 1 each: status.

Function
REQ-016 SHALL implement states PWRUP, CONFIG, READY, ARM, CAPTURE, each encoded distinctly.
REQ-017 PWRUP SHALL count PWRUP_CYCLES clk cycles, then go to CONFIG and pulse cfg_start for exactly one cycle.
REQ-018 CONFIG SHALL wait until cfg_done=1, then go to READY; cfg_done SHALL be ignored in every other state.
REQ-019 READY SHALL go to ARM on capture_req=1; capture_req SHALL be ignored in every other state.
REQ-020 ARM SHALL wait for frame_done=1, then enter CAPTURE with the pixel counter at 0, so capture always starts on a frame boundary.
REQ-021 In CAPTURE, each pixel_valid SHALL produce wr_en=1 exactly one cycle later, with wr_addr = the pixel counter value and wr_data = {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]}.
REQ-022 After each write, the pixel counter SHALL increment by 1.
REQ-023 The pixel counter SHALL stop at H_ACTIVE*V_ACTIVE; further pixel_valid strobes in that frame SHALL produce no write and SHALL set overrun (sticky).
REQ-024 On frame_done in CAPTURE, frame_ready SHALL pulse for exactly one cycle.
REQ-025 On frame_done in CAPTURE, short_frame SHALL be set (sticky) if the counter is < H_ACTIVE*V_ACTIVE.
REQ-026 On frame_done in CAPTURE, the counter SHALL clear to 0.
REQ-027 On frame_done in CAPTURE, the next state SHALL be CAPTURE if continuous=1, otherwise READY.
REQ-028 If pixel_valid and frame_done occur in the same CAPTURE cycle, the pixel SHALL be written at the pre-clear address before the counter clears; in ARM the pixel SHALL be dropped.
REQ-029 pixel_valid outside CAPTURE SHALL produce no write.
REQ-030 busy SHALL be 1 in PWRUP, CONFIG, ARM and CAPTURE, and 0 only in READY.
REQ-031 capture_req in READY SHALL clear overrun and short_frame.

Reset
REQ-032 While rst_n=0 the block SHALL be in PWRUP with the counter cleared and the power-up counter cleared.
REQ-033 While rst_n=0 the outputs SHALL be: cfg_start=0, wr_en=0, wr_addr=0, wr_data=0, busy=1, frame_ready=0, overrun=0, short_frame=0.
REQ-034 Reset asserted mid-capture SHALL abort immediately with no further writes, and the full power-up/config sequence SHALL repeat after release.

Verification
REQ-035 Power-up: PWRUP_CYCLES=8, release reset -> cfg_start is high for exactly 1 cycle, 8 cycles after release; cfg_done raised 5 cycles later -> busy=0 on the next cycle.
REQ-036 Single frame: H_ACTIVE=4, V_ACTIVE=2, capture_req, frame_done, 8 pixels 0xFFFF, frame_done -> writes at addr 0..7 with data 0xFFF, one frame_ready pulse, return to READY, short_frame=0.
REQ-037 Overrun: same parameters, 10 pixels in the frame -> exactly 8 writes, overrun=1 after the 9th pixel; the next capture_req clears it.
REQ-038 Short frame plus continuous: continuous=1, frames of 5 then 8 pixels -> short_frame=1, second frame written from addr 0, state stays CAPTURE.
REQ-039 Simultaneous/reset: pixel_valid coincident with frame_done writes the last address; rst_n low mid-frame -> wr_en=0 immediately and cfg_start is re-issued after PWRUP_CYCLES.
